// File: rtl/led_pattern_gen.sv
// LED pattern engine: COUNT / SCAN / BREATHE / STATIC patterns advanced by a programmable tick prescaler.
// Latency: leds registered, pattern change visible 2 clks after the tick event (1 clk after tick pulse).
// Backpressure: none; en=0 freezes prescaler, pattern state, PWM counter, leds, and forces tick low.
module led_pattern_gen #(
  parameter int NUM_LEDS = 8,
  parameter int DIV      = 262144,
  parameter int PWM_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] static_pat,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  // Position after bouncing off the top end; unused when there is a single LED.
  localparam logic [POS_W-1:0]    POS_TURN = POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);
  localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
  localparam logic [PWM_W-1:0]    DUTY_MAX = '1;
  localparam logic [PWM_W-1:0]    DUTY_TOP = DUTY_MAX - PWM_W'(1);
  localparam logic [PWM_W-1:0]    DUTY_ONE = PWM_W'(1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    M_COUNT   = 2'd0,
    M_SCAN    = 2'd1,
    M_BREATHE = 2'd2,
    M_STATIC  = 2'd3
  } mode_e;

  typedef enum logic {
    D_UP   = 1'b0,
    D_DOWN = 1'b1
  } dir_e;

  // Current state
  logic [PS_W-1:0]     presc;
  mode_e               mode_q;
  logic [NUM_LEDS-1:0] cnt;
  logic [POS_W-1:0]    pos;
  dir_e                dir;
  logic [PWM_W-1:0]    duty;
  dir_e                ramp;
  logic [PWM_W-1:0]    pwm_cnt;

  // Next state
  logic [PS_W-1:0]     presc_nxt;
  mode_e               mode_nxt;
  logic [NUM_LEDS-1:0] cnt_nxt;
  logic [POS_W-1:0]    pos_nxt;
  dir_e                dir_nxt;
  logic [PWM_W-1:0]    duty_nxt;
  dir_e                ramp_nxt;
  logic [PWM_W-1:0]    pwm_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic                tick_nxt;
  logic                tick_evt;

  // State register: everything clears on reset, then loads the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      mode_q  <= M_COUNT;
      cnt     <= '0;
      pos     <= '0;
      dir     <= D_UP;
      duty    <= '0;
      ramp    <= D_UP;
      pwm_cnt <= '0;
      leds    <= '0;
      tick    <= 1'b0;
    end else begin
      presc   <= presc_nxt;
      mode_q  <= mode_nxt;
      cnt     <= cnt_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      duty    <= duty_nxt;
      ramp    <= ramp_nxt;
      pwm_cnt <= pwm_nxt;
      leds    <= leds_nxt;
      tick    <= tick_nxt;
    end
  end

  // Next-state logic: prescaler, mode latch, pattern advance and LED drive.
  always_comb begin
    presc_nxt = presc;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    pos_nxt   = pos;
    dir_nxt   = dir;
    duty_nxt  = duty;
    ramp_nxt  = ramp;
    pwm_nxt   = pwm_cnt;
    leds_nxt  = leds;
    tick_evt  = en && (presc == PS_LAST);
    tick_nxt  = tick_evt;

    if (en) begin
      presc_nxt = tick_evt ? '0 : presc + 1'b1;
      pwm_nxt   = pwm_cnt + 1'b1;

      // LEDs reflect the pattern state as it stands before this edge.
      case (mode_q)
        M_COUNT:   leds_nxt = cnt;
        M_SCAN:    leds_nxt = LED_ONE << pos;
        M_BREATHE: leds_nxt = {NUM_LEDS{pwm_cnt < duty}};
        default:   leds_nxt = static_pat;
      endcase

      if (tick_evt) begin
        if (mode_e'(mode) != mode_q) begin
          // A new mode starts its pattern from scratch instead of advancing.
          mode_nxt = mode_e'(mode);
          cnt_nxt  = '0;
          pos_nxt  = '0;
          dir_nxt  = D_UP;
          duty_nxt = '0;
          ramp_nxt = D_UP;
        end else begin
          case (mode_q)
            M_COUNT: cnt_nxt = cnt + 1'b1;
            M_SCAN: begin
              if (NUM_LEDS == 1) begin
                pos_nxt = '0;
              end else if (dir == D_UP) begin
                if (pos == POS_LAST) begin
                  dir_nxt = D_DOWN;
                  pos_nxt = POS_TURN;
                end else begin
                  pos_nxt = pos + 1'b1;
                end
              end else begin
                if (pos == '0) begin
                  dir_nxt = D_UP;
                  pos_nxt = POS_ONE;
                end else begin
                  pos_nxt = pos - 1'b1;
                end
              end
            end
            M_BREATHE: begin
              if (ramp == D_UP) begin
                if (duty == DUTY_MAX) begin
                  ramp_nxt = D_DOWN;
                  duty_nxt = DUTY_TOP;
                end else begin
                  duty_nxt = duty + 1'b1;
                end
              end else begin
                if (duty == '0) begin
                  ramp_nxt = D_UP;
                  duty_nxt = DUTY_ONE;
                end else begin
                  duty_nxt = duty - 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed phases then random en/mode/static_pat/reset stimulus.
// Two instances (4 LEDs and 1 LED, DIV=4, PWM_W=2) checked every cycle against a step-index model.
// Model derives each pattern from the number of ticks since the mode was entered.
module tb_led_pattern_gen;

  localparam int DIV = 4;
  localparam int PWM = 4;   // 2^PWM_W

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] static_pat;
  logic [3:0] leds;
  logic       tick;
  logic [0:0] leds1;
  logic       tick1;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: enabled-cycle count, mode in effect, ticks since that mode began.
  int         ec;
  int         k;
  logic [1:0] mq;
  logic [3:0] exp_leds;
  logic       exp_leds1;
  logic       exp_tick;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(4), .DIV(DIV), .PWM_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .static_pat(static_pat), .leds(leds), .tick(tick)
  );

  led_pattern_gen #(.NUM_LEDS(1), .DIV(DIV), .PWM_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .static_pat(static_pat[0:0]), .leds(leds1), .tick(tick1)
  );

  // Pattern for n LEDs, kk ticks into mode md, given PWM phase and static input.
  function automatic logic [3:0] pat(int n, logic [1:0] md, int kk, int pwm, logic [3:0] sp);
    int p;
    int per;
    int d;
    logic [3:0] r;
    r = '0;
    case (md)
      2'd0: r = 4'(kk % (1 << n));
      2'd1: begin
        if (n == 1) r = 4'd1;
        else begin
          per = 2 * n - 2;
          p   = kk % per;
          if (p >= n) p = per - p;
          r = 4'(1 << p);
        end
      end
      2'd2: begin
        per = 2 * (PWM - 1);
        p   = kk % per;
        d   = (p <= PWM - 1) ? p : per - p;
        r   = (pwm < d) ? 4'((1 << n) - 1) : 4'd0;
      end
      default: r = sp & 4'((1 << n) - 1);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    ec = 0; k = 0; mq = 2'd0;
    exp_leds = '0; exp_leds1 = 1'b0; exp_tick = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_step();
    if (!rst_n) model_reset();
    else if (en) begin
      exp_leds  = pat(4, mq, k, ec % PWM, static_pat);
      exp_leds1 = pat(1, mq, k, ec % PWM, static_pat)[0];
      exp_tick  = (ec % DIV) == DIV - 1;
      if (exp_tick) begin
        if (mode != mq) begin
          mq = mode;
          k  = 0;
        end else begin
          k++;
        end
      end
      ec++;
    end else begin
      exp_tick = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [3:0] got, logic [3:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("leds", leds, exp_leds);
    chk("tick", {3'b0, tick}, {3'b0, exp_tick});
    chk("leds1", {3'b0, leds1}, {3'b0, exp_leds1});
    chk("tick1", {3'b0, tick1}, {3'b0, exp_tick});
  endtask

  // Run n cycles; returns at a falling edge with outputs checked.
  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_leds", leds, 4'd0);
    chk("rst_tick", {3'b0, tick}, 4'd0);
    chk("rst_leds1", {3'b0, leds1}, 4'd0);
    run(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; static_pat = 4'd0;
    model_reset();
    @(negedge clk);
    check_all();
    run(2);
    rst_n = 1'b1;

    // COUNT through a full wrap.
    en = 1'b1; mode = 2'd0;
    run(70);
    // SCAN: first tick switches mode, then bounces.
    mode = 2'd1;
    run(40);
    // BREATHE duty ramp.
    mode = 2'd2;
    run(60);
    // Back to COUNT, then a brief STATIC glitch between ticks.
    mode = 2'd0;
    run(10);
    while (ec % DIV != 0) run(1);
    mode = 2'd3; run(1);
    mode = 2'd0; run(1);
    run(8);
    // STATIC held across ticks.
    mode = 2'd3; static_pat = 4'b1010;
    run(12);
    for (int i = 0; i < 10; i++) begin
      static_pat = 4'($urandom);
      run(1);
    end
    // COUNT, then freeze for 10 clocks mid-count.
    mode = 2'd0;
    run(30);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(10);
    // SCAN interrupted by reset.
    mode = 2'd1;
    run(20);
    do_reset();
    run(30);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      static_pat = 4'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
